console_text_source: RTL and testbench
======================================

// Module: console_text_source
// PURPOSE
//   Parametrised character/attribute generator feeding the console text renderer from hdmi cx/cy.
//   Successor to the fixed per-row counter: configurable glyph geometry, character range and wrap,
//   four fill modes (row, column, grid, scrolling rows), a derived colour attribute and a frame tick.
//   Sits between the hdmi timing outputs (cx, cy) and console (character, attribute) in clk_pixel domain.
// PARAMETERS
//   BIT_WIDTH     10     width of cx
//   BIT_HEIGHT    10     width of cy
//   GLYPH_W       8      glyph width in pixels, power of two
//   GLYPH_H       16     glyph height in pixels, power of two
//   COLS          80     text columns per row (GRID stride); must satisfy 1 <= COLS < CHAR_RANGE
//   FIRST_CHAR    8'h20  lowest character code emitted
//   CHAR_RANGE    95     number of codes; FIRST_CHAR+CHAR_RANGE <= 256
//   SCROLL_FRAMES 30     frames per scroll step in SCROLL mode, >= 1
//   ATTR_SEED     8'h00  XOR mask applied to attribute
// PORTS
//   clk_pixel  in   1           pixel clock; all state on rising edge
//   reset      in   1           synchronous, active-high reset
//   cx         in   BIT_WIDTH   current pixel x (hdmi frame coordinates, incl. blanking)
//   cy         in   BIT_HEIGHT  current pixel y
//   mode       in   2           0 ROW, 1 COL, 2 GRID, 3 SCROLL; sampled at frame start only
//   character  out  8           code to console
//   attribute  out  8           colour attribute to console
//   frame_tick out  1           one-cycle pulse per frame
// BEHAVIOUR
//   Reset (sync, high): character=FIRST_CHAR, attribute=8'h00, frame_tick=0, active mode=ROW,
//     scroll offset=0, frame counter=0, row/col trackers=0. Reset mid-frame takes effect next edge.
//   row_idx = cy >> log2(GLYPH_H); col_idx = cx >> log2(GLYPH_W). Trackers prev_row/prev_col registered.
//   All outputs registered: values reflect cx/cy sampled on the previous edge (latency 1 cycle).
//   Wrap rule: code arithmetic is modulo CHAR_RANGE offset by FIRST_CHAR; incr from
//     FIRST_CHAR+CHAR_RANGE-1 gives FIRST_CHAR; adding COLS subtracts CHAR_RANGE once if overflowing.
//   Frame start = cx==0 && cy==0: frame_tick<=1 (else 0); active mode<=mode; base<=FIRST_CHAR+offset;
//     character<=base; row_start<=base; prev_row<=0; prev_col<=0.
//   SCROLL offset: frame counter counts frame starts while active mode is SCROLL; at SCROLL_FRAMES
//     it clears and offset advances by 1 (wrap at CHAR_RANGE). In other modes offset and counter hold.
//   ROW / SCROLL: on row_idx != prev_row: character<=character+1, prev_row<=row_idx. cx ignored.
//   COL: on cx==0: character<=base, prev_col<=0; else on col_idx != prev_col: character+1.
//   GRID: on row_idx != prev_row: row_start<=row_start+COLS; character<=row_start+COLS.
//     on cx==0 (same row): character<=row_start. else col_idx change: character+1.
//   Frame start has priority over row change, row change over cx==0, cx==0 over column change.
//   attribute <= {row_idx[3:0], col_idx[3:0]} ^ ATTR_SEED, every cycle.
//   mode changes mid-frame have no effect until next frame start; frame_tick exactly once per frame.
// TESTING
//   Reset 3 cycles at cy=100 -> character=8'h20, attribute=8'h00, frame_tick=0; resumes at next frame.
//   ROW: cy=0 -> 8'h20; cy steps 15->16 -> 8'h21 one cycle later; cy=479 (row 29) -> 8'h3D.
//   GRID: row1 col0 -> 8'h70; row1 col15 -> wraps to 8'h20; row2 col0 -> 8'h61.
//   SCROLL: after 30 frame_ticks row0 char=8'h21; after 95*30 frames row0 char back to 8'h20.
//   mode 0->1 driven at cy=100 -> row behaviour until next cx=0,cy=0, then COL (col 5 -> 8'h25).
//   Over 4 frames of 800x525 timing -> exactly 4 frame_tick pulses, each 1 cycle after cx=0,cy=0.

Source files
------------

// File: rtl/console_text_source.sv
// Character/attribute generator for the console text renderer.
// Turns hdmi pixel coordinates into a character code and colour attribute.
// Fill modes: ROW, COL, GRID and SCROLL (ROW with an offset that advances slowly).
// Ports:
//   clk_pixel  - pixel clock; all state changes on the rising edge
//   reset      - synchronous, active-high
//   cx, cy     - current pixel coordinates, blanking included
//   mode       - fill mode request; taken only at frame start (cx==0 && cy==0)
//   character  - registered character code (one cycle behind cx/cy)
//   attribute  - registered {row[3:0], col[3:0]} ^ ATTR_SEED
//   frame_tick - one-cycle pulse, one cycle after each frame start
module console_text_source #(
  parameter int unsigned BIT_WIDTH     = 10,
  parameter int unsigned BIT_HEIGHT    = 10,
  parameter int unsigned GLYPH_W       = 8,
  parameter int unsigned GLYPH_H       = 16,
  parameter int unsigned COLS          = 80,
  parameter logic [7:0]  FIRST_CHAR    = 8'h20,
  parameter int unsigned CHAR_RANGE    = 95,
  parameter int unsigned SCROLL_FRAMES = 30,
  parameter logic [7:0]  ATTR_SEED     = 8'h00
) (
  input  logic                  clk_pixel,
  input  logic                  reset,
  input  logic [BIT_WIDTH-1:0]  cx,
  input  logic [BIT_HEIGHT-1:0] cy,
  input  logic [1:0]            mode,
  output logic [7:0]            character,
  output logic [7:0]            attribute,
  output logic                  frame_tick
);

  localparam int unsigned GlyphWLog = $clog2(GLYPH_W);
  localparam int unsigned GlyphHLog = $clog2(GLYPH_H);
  localparam int unsigned LastCode  = int'(FIRST_CHAR) + CHAR_RANGE - 1;
  localparam int unsigned CntW      = $clog2(SCROLL_FRAMES + 1);

  typedef enum logic [1:0] {
    ModeRow    = 2'd0,
    ModeCol    = 2'd1,
    ModeGrid   = 2'd2,
    ModeScroll = 2'd3
  } mode_e;

  // Next code in the range, wrapping from the last code back to FIRST_CHAR.
  function automatic logic [7:0] code_inc(input logic [7:0] c);
    if (c == 8'(LastCode)) return FIRST_CHAR;
    return c + 8'd1;
  endfunction

  // Add n (< CHAR_RANGE) to a code; a single subtraction suffices to wrap.
  function automatic logic [7:0] code_add(input logic [7:0] c, input int unsigned n);
    logic [8:0] s;
    s = {1'b0, c} + 9'(n);
    if (s > 9'(LastCode)) s = s - 9'(CHAR_RANGE);
    return s[7:0];
  endfunction

  logic [BIT_HEIGHT-1:0] row_idx;
  logic [BIT_WIDTH-1:0]  col_idx;
  logic                  frame_start;

  assign row_idx     = cy >> GlyphHLog;
  assign col_idx     = cx >> GlyphWLog;
  assign frame_start = (cx == '0) && (cy == '0);

  logic [7:0]            character_q, character_d;
  logic [7:0]            attribute_q, attribute_d;
  logic                  frame_tick_q, frame_tick_d;
  mode_e                 mode_q, mode_d;
  logic [7:0]            offset_q, offset_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [7:0]            base_q, base_d;
  logic [7:0]            row_start_q, row_start_d;
  logic [BIT_HEIGHT-1:0] prev_row_q, prev_row_d;
  logic [BIT_WIDTH-1:0]  prev_col_q, prev_col_d;

  always_comb begin
    character_d  = character_q;
    attribute_d  = {row_idx[3:0], col_idx[3:0]} ^ ATTR_SEED;
    frame_tick_d = 1'b0;
    mode_d       = mode_q;
    offset_d     = offset_q;
    cnt_d        = cnt_q;
    base_d       = base_q;
    row_start_d  = row_start_q;
    prev_row_d   = prev_row_q;
    prev_col_d   = prev_col_q;

    if (frame_start) begin
      frame_tick_d = 1'b1;
      mode_d       = mode_e'(mode);
      // Scroll pacing counts frames that were displayed in SCROLL mode.
      if (mode_q == ModeScroll) begin
        if (cnt_q == CntW'(SCROLL_FRAMES - 1)) begin
          cnt_d    = '0;
          offset_d = (offset_q == 8'(CHAR_RANGE - 1)) ? 8'd0 : offset_q + 8'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      base_d      = FIRST_CHAR + offset_d;
      character_d = base_d;
      row_start_d = base_d;
      prev_row_d  = '0;
      prev_col_d  = '0;
    end else begin
      case (mode_q)
        ModeRow, ModeScroll: begin
          if (row_idx != prev_row_q) begin
            character_d = code_inc(character_q);
            prev_row_d  = row_idx;
          end
        end
        ModeCol: begin
          if (cx == '0) begin
            character_d = base_q;
            prev_col_d  = '0;
          end else if (col_idx != prev_col_q) begin
            character_d = code_inc(character_q);
            prev_col_d  = col_idx;
          end
        end
        ModeGrid: begin
          if (row_idx != prev_row_q) begin
            row_start_d = code_add(row_start_q, COLS);
            character_d = row_start_d;
            prev_row_d  = row_idx;
            // Resync the column tracker so the new row does not see a stale column.
            prev_col_d  = col_idx;
          end else if (cx == '0) begin
            character_d = row_start_q;
            prev_col_d  = '0;
          end else if (col_idx != prev_col_q) begin
            character_d = code_inc(character_q);
            prev_col_d  = col_idx;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      character_q  <= FIRST_CHAR;
      attribute_q  <= 8'h00;
      frame_tick_q <= 1'b0;
      mode_q       <= ModeRow;
      offset_q     <= 8'd0;
      cnt_q        <= '0;
      base_q       <= FIRST_CHAR;
      row_start_q  <= FIRST_CHAR;
      prev_row_q   <= '0;
      prev_col_q   <= '0;
    end else begin
      character_q  <= character_d;
      attribute_q  <= attribute_d;
      frame_tick_q <= frame_tick_d;
      mode_q       <= mode_d;
      offset_q     <= offset_d;
      cnt_q        <= cnt_d;
      base_q       <= base_d;
      row_start_q  <= row_start_d;
      prev_row_q   <= prev_row_d;
      prev_col_q   <= prev_col_d;
    end
  end

  assign character  = character_q;
  assign attribute  = attribute_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_console_text_source.sv
// Self-checking bench for console_text_source.
// The reference model gives the expected character of a raster scan in closed form:
// FIRST + (offset + f(row, col)) mod RANGE, with f = row, col or row*COLS+col.
module tb_console_text_source;

  localparam int         FIRST = 32;
  localparam int         RANGE = 95;
  localparam int         NCOLS = 80;
  localparam int         SF    = 30;
  localparam logic [7:0] SEED  = 8'hA5;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] cx;
  logic [9:0] cy;
  logic [1:0] mode;
  logic [7:0] character;
  logic [7:0] attribute;
  logic       frame_tick;

  console_text_source #(
    .BIT_WIDTH    (10),
    .BIT_HEIGHT   (10),
    .GLYPH_W      (8),
    .GLYPH_H      (16),
    .COLS         (NCOLS),
    .FIRST_CHAR   (8'h20),
    .CHAR_RANGE   (RANGE),
    .SCROLL_FRAMES(SF),
    .ATTR_SEED    (SEED)
  ) dut (
    .clk_pixel (clk),
    .reset     (reset),
    .cx        (cx),
    .cy        (cy),
    .mode      (mode),
    .character (character),
    .attribute (attribute),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int         m_off, m_cnt, m_act;
  logic [7:0] e_char, e_attr;
  logic       e_tick;

  task automatic model_reset();
    m_off = 0;
    m_cnt = 0;
    m_act = 0;
  endtask

  // Expected outputs one cycle after pixel (x, y) with mode input m, in a raster scan.
  task automatic model_pixel(input int x, input int y, input int m);
    int row, col, f;
    row    = y / 16;
    col    = x / 8;
    e_tick = (x == 0 && y == 0);
    if (e_tick) begin
      if (m_act == 3) begin
        m_cnt++;
        if (m_cnt == SF) begin
          m_cnt = 0;
          m_off = (m_off + 1) % RANGE;
        end
      end
      m_act = m;
    end
    case (m_act)
      1:       f = col;
      2:       f = row * NCOLS + col;
      default: f = row;
    endcase
    e_char = 8'(FIRST + (m_off + f) % RANGE);
    e_attr = 8'((row % 16) * 16 + (col % 16)) ^ SEED;
  endtask

  task automatic apply(input int x, input int y, input int m);
    cx   = 10'(x);
    cy   = 10'(y);
    mode = 2'(m);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int m;
    reset = 1'b1;
    apply(5, 100, 0);
    apply(5, 100, 0);
    reset = 1'b0;
    for (int y = 0; y < 40; y++) for (int x = 0; x < 4; x++) apply(x, y, 0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      apply(3, 100, int'($urandom_range(0, 3)));
      n_cmp++;
      if (character !== 8'h20) begin
        n_err++; $display("FAIL reset_char cycle %0d: got %h want 20", i, character);
      end
      n_cmp++;
      if (attribute !== 8'h00) begin
        n_err++; $display("FAIL reset_attr cycle %0d: got %h want 00", i, attribute);
      end
      n_cmp++;
      if (frame_tick !== 1'b0) begin
        n_err++; $display("FAIL reset_tick cycle %0d: got %b want 0", i, frame_tick);
      end
    end
    reset = 1'b0;
    apply(4, 100, 1);
    apply(5, 101, 2);
    model_reset();
    for (int y = 0; y < 64; y++) begin
      for (int x = 0; x < 4; x++) begin
        m = (x == 0 && y == 0) ? 0 : int'($urandom_range(0, 3));
        model_pixel(x, y, m);
        apply(x, y, m);
        n_cmp++;
        if (character !== e_char) begin
          n_err++; $display("FAIL resume_char (%0d,%0d): got %h want %h", x, y, character, e_char);
        end
        n_cmp++;
        if (attribute !== e_attr) begin
          n_err++; $display("FAIL resume_attr (%0d,%0d): got %h want %h", x, y, attribute, e_attr);
        end
      end
    end
  endtask

  task automatic test_row();
    int m;
    for (int y = 0; y < 525; y++) begin
      for (int x = 0; x < 4; x++) begin
        m = (x == 0 && y == 0) ? 0 : int'($urandom_range(0, 3));
        model_pixel(x, y, m);
        apply(x, y, m);
        n_cmp++;
        if (character !== e_char) begin
          n_err++; $display("FAIL row_char (%0d,%0d): got %h want %h", x, y, character, e_char);
        end
        n_cmp++;
        if (frame_tick !== e_tick) begin
          n_err++; $display("FAIL row_tick (%0d,%0d): got %b want %b", x, y, frame_tick, e_tick);
        end
        if (x == 0 && y == 15 && character !== 8'h20) begin
          n_err++; $display("FAIL row_cy15: got %h want 20", character);
        end
        if (x == 0 && y == 16 && character !== 8'h21) begin
          n_err++; $display("FAIL row_cy16: got %h want 21", character);
        end
        if (x == 0 && y == 479 && character !== 8'h3D) begin
          n_err++; $display("FAIL row_cy479: got %h want 3d", character);
        end
        if (x == 0 && (y == 15 || y == 16 || y == 479)) n_cmp++;
      end
    end
  endtask

  task automatic test_grid();
    int m;
    for (int y = 0; y < 48; y++) begin
      for (int x = 0; x < 136; x++) begin
        m = (x == 0 && y == 0) ? 2 : int'($urandom_range(0, 3));
        model_pixel(x, y, m);
        apply(x, y, m);
        n_cmp++;
        if (character !== e_char) begin
          n_err++; $display("FAIL grid_char (%0d,%0d): got %h want %h", x, y, character, e_char);
        end
        n_cmp++;
        if (attribute !== e_attr) begin
          n_err++; $display("FAIL grid_attr (%0d,%0d): got %h want %h", x, y, attribute, e_attr);
        end
        if (x == 0 && y == 16) begin
          n_cmp++;
          if (character !== 8'h70) begin
            n_err++; $display("FAIL grid_r1c0: got %h want 70", character);
          end
        end
        if (x == 120 && y == 16) begin
          n_cmp++;
          if (character !== 8'h20) begin
            n_err++; $display("FAIL grid_r1c15: got %h want 20", character);
          end
        end
        if (x == 0 && y == 32) begin
          n_cmp++;
          if (character !== 8'h61) begin
            n_err++; $display("FAIL grid_r2c0: got %h want 61", character);
          end
        end
      end
    end
  endtask

  task automatic test_scroll();
    int m;
    reset = 1'b1;
    apply(1, 1, 0);
    reset = 1'b0;
    model_reset();
    for (int k = 0; k <= RANGE * SF; k++) begin
      model_pixel(0, 0, 3);
      apply(0, 0, 3);
      n_cmp++;
      if (character !== e_char) begin
        n_err++; $display("FAIL scroll_char frame %0d: got %h want %h", k, character, e_char);
      end
      n_cmp++;
      if (frame_tick !== 1'b1) begin
        n_err++; $display("FAIL scroll_tick frame %0d: got %b want 1", k, frame_tick);
      end
      if (k == SF) begin
        n_cmp++;
        if (character !== 8'h21) begin
          n_err++; $display("FAIL scroll_step1: got %h want 21", character);
        end
      end
      if (k == RANGE * SF - 1) begin
        n_cmp++;
        if (character !== 8'h7E) begin
          n_err++; $display("FAIL scroll_last: got %h want 7e", character);
        end
      end
      if (k == RANGE * SF) begin
        n_cmp++;
        if (character !== 8'h20) begin
          n_err++; $display("FAIL scroll_wrap: got %h want 20", character);
        end
      end
      m = int'($urandom_range(0, 3));
      model_pixel(8, 0, m);
      apply(8, 0, m);
      n_cmp++;
      if (character !== e_char || frame_tick !== 1'b0) begin
        n_err++;
        $display("FAIL scroll_mid frame %0d: got %h/%b want %h/0", k, character, frame_tick, e_char);
      end
    end
  endtask

  task automatic test_mode_switch();
    int m;
    reset = 1'b1;
    apply(2, 2, 0);
    reset = 1'b0;
    model_reset();
    for (int y = 0; y < 120; y++) begin
      for (int x = 0; x < 48; x++) begin
        m = (y < 100) ? 0 : 1;
        model_pixel(x, y, m);
        apply(x, y, m);
        n_cmp++;
        if (character !== e_char) begin
          n_err++; $display("FAIL sw_row_char (%0d,%0d): got %h want %h", x, y, character, e_char);
        end
        if (x == 40 && y == 112) begin
          n_cmp++;
          if (character !== 8'h27) begin
            n_err++; $display("FAIL sw_still_row: got %h want 27", character);
          end
        end
      end
    end
    for (int y = 0; y < 16; y++) begin
      for (int x = 0; x < 48; x++) begin
        model_pixel(x, y, 1);
        apply(x, y, 1);
        n_cmp++;
        if (character !== e_char) begin
          n_err++; $display("FAIL sw_col_char (%0d,%0d): got %h want %h", x, y, character, e_char);
        end
        if (x == 40 && y == 0) begin
          n_cmp++;
          if (character !== 8'h25) begin
            n_err++; $display("FAIL sw_col5: got %h want 25", character);
          end
        end
      end
    end
  endtask

  task automatic test_frame_tick();
    int m, w, h, fm, ticks;
    ticks = 0;
    w = int'($urandom_range(64, 120));
    h = int'($urandom_range(32, 64));
    for (int f = 0; f < 4; f++) begin
      fm = int'($urandom_range(0, 3));
      for (int y = 0; y < h; y++) begin
        for (int x = 0; x < w; x++) begin
          m = (x == 0 && y == 0) ? fm : int'($urandom_range(0, 3));
          model_pixel(x, y, m);
          apply(x, y, m);
          if (frame_tick === 1'b1) ticks++;
          n_cmp++;
          if (frame_tick !== e_tick) begin
            n_err++; $display("FAIL tick (%0d,%0d) f%0d: got %b want %b", x, y, f, frame_tick, e_tick);
          end
          n_cmp++;
          if (character !== e_char) begin
            n_err++;
            $display("FAIL rand_char (%0d,%0d) mode %0d: got %h want %h", x, y, fm, character, e_char);
          end
          n_cmp++;
          if (attribute !== e_attr) begin
            n_err++; $display("FAIL rand_attr (%0d,%0d): got %h want %h", x, y, attribute, e_attr);
          end
        end
      end
    end
    n_cmp++;
    if (ticks != 4) begin
      n_err++; $display("FAIL tick_count: got %0d want 4", ticks);
    end
  endtask

  initial begin
    reset = 1'b1;
    cx    = '0;
    cy    = '0;
    mode  = '0;
    model_reset();
    test_reset();
    test_row();
    test_grid();
    test_scroll();
    test_mode_switch();
    test_frame_tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
